// File: rtl/aclk_pkg.sv
// rtl/aclk_pkg.sv - shared BCD time-of-day types, digit limits and legality check
//
// Purpose: common definitions for the alarm-clock time path. The key-entry
// and alarm-register blocks reuse the same digit type, limits and legality
// check.
// Contents: bcd_t, digit limit constants, bcd_time_legal().
package aclk_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX        = 4'd9;  // highest value of any BCD units digit
  localparam bcd_t MIN_LS_MAX     = 4'd9;
  localparam bcd_t MIN_MS_MAX     = 4'd5;
  localparam bcd_t HR_MS_MAX      = 4'd2;
  localparam bcd_t HR_LS_MAX_AT_2 = 4'd3;  // units-of-hour ceiling once tens is 2

  // True when the four digits form a legal 24-hour time 00:00..23:59.
  function automatic logic bcd_time_legal(input bcd_t ms_hr, input bcd_t ls_hr,
                                          input bcd_t ms_min, input bcd_t ls_min);
    logic hr_ok;
    if (ms_hr < HR_MS_MAX)       hr_ok = (ls_hr <= BCD_MAX);
    else if (ms_hr == HR_MS_MAX) hr_ok = (ls_hr <= HR_LS_MAX_AT_2);
    else                         hr_ok = 1'b0;
    return hr_ok && (ms_min <= MIN_MS_MAX) && (ls_min <= MIN_LS_MAX);
  endfunction

endpackage

// File: rtl/aclk_bcd_digit.sv
// rtl/aclk_bcd_digit.sv - single BCD digit register with load, clear, increment and wrap
//
// Purpose: one time-of-day digit. Priority: reset > load > clear > increment.
// Incrementing at i_limit wraps to 0 and raises o_carry in the same cycle.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   i_clr          force digit to 0 on the next edge
//   i_ld, i_ld_val load i_ld_val on the next edge
//   i_inc          increment enable
//   i_limit        wrap limit (may change dynamically)
//   o_q            registered digit value
//   o_carry        combinational carry-out: i_inc while o_q == i_limit
module aclk_bcd_digit
  import aclk_pkg::*;
#(
  parameter bcd_t RESET_VAL = 4'd0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_ld,
  input  bcd_t i_ld_val,
  input  logic i_inc,
  input  bcd_t i_limit,
  output bcd_t o_q,
  output logic o_carry
);

  bcd_t r_q;
  logic w_at_limit;

  assign w_at_limit = (r_q == i_limit);
  assign o_carry    = i_inc && w_at_limit;
  assign o_q        = r_q;

  always_ff @(posedge clock) begin
    if (reset)      r_q <= RESET_VAL;
    else if (i_ld)  r_q <= i_ld_val;
    else if (i_clr) r_q <= 4'd0;
    else if (i_inc) r_q <= w_at_limit ? 4'd0 : r_q + 4'd1;
  end

endmodule

// File: rtl/aclk_time_counter.sv
// rtl/aclk_time_counter.sv - 24-hour BCD time-of-day counter with validated load
//
// Purpose: holds HH:MM in four BCD digits, advances one minute per
// one_minute strobe and accepts validated loads. Optional macro
// ACLK_HOURLY_CHIME_EN adds a one-cycle chime pulse on every MM 59->00 tick.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   one_minute              single-cycle minute tick
//   load_new_c              single-cycle load request
//   new_{ms,ls}_{hr,min}    BCD digits to load
//   current_time_*          registered BCD digits
//   load_err                one-cycle pulse after a rejected load
//   chime                   (ACLK_HOURLY_CHIME_EN only) one-cycle pulse after hour rollover
module aclk_time_counter
  import aclk_pkg::*;
#(
  parameter logic [7:0] RESET_HR  = 8'h00,
  parameter logic [7:0] RESET_MIN = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_minute,
  input  logic       load_new_c,
  input  logic [3:0] new_ms_hr,
  input  logic [3:0] new_ls_hr,
  input  logic [3:0] new_ms_min,
  input  logic [3:0] new_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
`ifdef ACLK_HOURLY_CHIME_EN
  output logic       chime,
`endif
  output logic       load_err
);

  logic w_load_ok;
  logic w_tick;
  logic w_c_ls_min, w_c_ms_min, w_c_ls_hr, w_c_ms_hr;
  logic w_day_wrap;
  bcd_t w_ls_hr_lim;
  logic r_load_err;

  assign w_load_ok = load_new_c && bcd_time_legal(new_ms_hr, new_ls_hr, new_ms_min, new_ls_min);
  // A load request (legal or not) swallows a coincident tick.
  assign w_tick    = one_minute && !load_new_c;

  assign w_ls_hr_lim = (current_time_ms_hr == HR_MS_MAX) ? HR_LS_MAX_AT_2 : BCD_MAX;
  // Tens-of-hour carrying out means 23:59 -> 00:00; clear both hour digits together.
  assign w_day_wrap  = w_c_ms_hr;

  aclk_bcd_digit #(.RESET_VAL(RESET_MIN[3:0])) u_ls_min (
    .clock(clock), .reset(reset), .i_clr(1'b0), .i_ld(w_load_ok), .i_ld_val(new_ls_min),
    .i_inc(w_tick), .i_limit(MIN_LS_MAX), .o_q(current_time_ls_min), .o_carry(w_c_ls_min)
  );

  aclk_bcd_digit #(.RESET_VAL(RESET_MIN[7:4])) u_ms_min (
    .clock(clock), .reset(reset), .i_clr(1'b0), .i_ld(w_load_ok), .i_ld_val(new_ms_min),
    .i_inc(w_c_ls_min), .i_limit(MIN_MS_MAX), .o_q(current_time_ms_min), .o_carry(w_c_ms_min)
  );

  aclk_bcd_digit #(.RESET_VAL(RESET_HR[3:0])) u_ls_hr (
    .clock(clock), .reset(reset), .i_clr(w_day_wrap), .i_ld(w_load_ok), .i_ld_val(new_ls_hr),
    .i_inc(w_c_ms_min), .i_limit(w_ls_hr_lim), .o_q(current_time_ls_hr), .o_carry(w_c_ls_hr)
  );

  aclk_bcd_digit #(.RESET_VAL(RESET_HR[7:4])) u_ms_hr (
    .clock(clock), .reset(reset), .i_clr(w_day_wrap), .i_ld(w_load_ok), .i_ld_val(new_ms_hr),
    .i_inc(w_c_ls_hr), .i_limit(HR_MS_MAX), .o_q(current_time_ms_hr), .o_carry(w_c_ms_hr)
  );

  always_ff @(posedge clock) begin
    if (reset) r_load_err <= 1'b0;
    else       r_load_err <= load_new_c && !w_load_ok;
  end
  assign load_err = r_load_err;

`ifdef ACLK_HOURLY_CHIME_EN
  logic r_chime;
  // Minute tens carrying out only happens on a tick through MM=59.
  always_ff @(posedge clock) begin
    if (reset) r_chime <= 1'b0;
    else       r_chime <= w_c_ms_min;
  end
  assign chime = r_chime;
`endif

endmodule

// File: tb/tb_aclk_time_counter.sv
// tb/tb_aclk_time_counter.sv - directed self-checking bench for aclk_time_counter
module tb_aclk_time_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_minute = 1'b0;
  logic       load_new_c = 1'b0;
  logic [3:0] new_ms_hr = 4'd0, new_ls_hr = 4'd0, new_ms_min = 4'd0, new_ls_min = 4'd0;
  logic [3:0] cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min;
  logic       load_err;
  logic [15:0] cur;
  int checks = 0;
  int errors = 0;
`ifdef ACLK_HOURLY_CHIME_EN
  logic chime;
`endif

  always #5 clock = ~clock;

  aclk_time_counter dut (
    .clock(clock), .reset(reset), .one_minute(one_minute), .load_new_c(load_new_c),
    .new_ms_hr(new_ms_hr), .new_ls_hr(new_ls_hr), .new_ms_min(new_ms_min), .new_ls_min(new_ls_min),
    .current_time_ms_hr(cur_ms_hr), .current_time_ls_hr(cur_ls_hr),
    .current_time_ms_min(cur_ms_min), .current_time_ls_min(cur_ls_min),
`ifdef ACLK_HOURLY_CHIME_EN
    .chime(chime),
`endif
    .load_err(load_err)
  );

  assign cur = {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_chime(input string tag, input logic exp);
`ifdef ACLK_HOURLY_CHIME_EN
    check(tag, {15'd0, chime}, {15'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_new(input logic [15:0] t);
    {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} = t;
  endtask

  // Load t with optional coincident tick; returns after the edge that acts on it.
  task automatic do_load(input logic [15:0] t, input logic tick);
    set_new(t);
    load_new_c = 1'b1;
    one_minute = tick;
    step();
    load_new_c = 1'b0;
    one_minute = 1'b0;
  endtask

  task automatic do_tick();
    one_minute = 1'b1;
    step();
    one_minute = 1'b0;
  endtask

  logic [15:0] bad_loads [3] = '{16'h2400, 16'h1960, 16'h2A00};

  initial begin
    #2;
    step();
    reset = 1'b0;
    check("reset_time", cur, 16'h0000);
    check("reset_err", {15'd0, load_err}, 16'h0000);
    chk_chime("reset_chime", 1'b0);

    step();
    check("hold_idle", cur, 16'h0000);

    do_load(16'h2358, 1'b0);
    check("load_2358", cur, 16'h2358);
    check("load_2358_err", {15'd0, load_err}, 16'h0000);
    do_tick();
    check("tick_2359", cur, 16'h2359);
    chk_chime("chime_2359", 1'b0);
    do_tick();
    check("wrap_0000", cur, 16'h0000);
    chk_chime("chime_wrap", 1'b1);
    step();
    check("hold_0000", cur, 16'h0000);
    chk_chime("chime_once", 1'b0);

    do_load(16'h0959, 1'b0);
    do_tick();
    check("carry_1000", cur, 16'h1000);
    chk_chime("chime_1000", 1'b1);

    do_load(16'h1959, 1'b0);
    do_tick();
    check("carry_2000", cur, 16'h2000);

    do_load(16'h2039, 1'b0);
    do_tick();
    check("min_tens_2040", cur, 16'h2040);
    chk_chime("chime_2040", 1'b0);

    do_load(16'h1234, 1'b0);
    check("load_1234", cur, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      do_load(bad_loads[i], 1'b0);
      check($sformatf("bad_%h_time", bad_loads[i]), cur, 16'h1234);
      check($sformatf("bad_%h_err", bad_loads[i]), {15'd0, load_err}, 16'h0001);
      step();
      check($sformatf("bad_%h_err_clr", bad_loads[i]), {15'd0, load_err}, 16'h0000);
    end

    do_load(16'h1200, 1'b0);
    check("load_1200", cur, 16'h1200);
    chk_chime("load_xx00_no_chime", 1'b0);

    do_load(16'h0714, 1'b0);
    do_load(16'h0715, 1'b1);
    check("load_beats_tick", cur, 16'h0715);
    do_tick();
    check("tick_0716", cur, 16'h0716);
    do_load(16'h3000, 1'b1);
    check("bad_load_drops_tick", cur, 16'h0716);
    check("bad_load_tick_err", {15'd0, load_err}, 16'h0001);

    reset = 1'b1;
    do_load(16'h1111, 1'b1);
    check("reset_vs_load", cur, 16'h0000);
    check("reset_vs_load_err", {15'd0, load_err}, 16'h0000);
    do_load(16'h2500, 1'b0);
    reset = 1'b0;
    check("reset_vs_bad_err", {15'd0, load_err}, 16'h0000);
    check("reset_vs_bad_time", cur, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
